// File: rtl/divide.sv
// Iterative restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Define DIVIDE_SIGNED_EN for two's-complement operands (adds a sign-fixup FIX state).
module divide #(
   parameter int unsigned N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   q,
   output logic [N-1:0]   r,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int unsigned CW = $clog2(N);

   typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;

   state_t         state;
   logic [2*N-1:0] a_reg;
   logic [N-1:0]   b_reg;
   logic [N-1:0]   p;
   logic [N-1:0]   s;
   logic [N-1:0]   q_res;
   logic [N-1:0]   r_res;
   logic [CW-1:0]  cnt;
   logic           dz;
   logic           ov;

   logic [2*N-1:0] a_mag;
   logic [N-1:0]   b_mag;
   logic [N:0]     shifted;
   logic [N:0]     t;
   logic           q_bit;
   logic [N-1:0]   p_next;
   logic [N-1:0]   s_next;

`ifdef DIVIDE_SIGNED_EN
   localparam logic [N-1:0] MIN_MAG = {1'b1, {(N-1){1'b0}}};
   logic neg_q;
   logic neg_r;

   assign a_mag = a_reg[2*N-1] ? -a_reg : a_reg;
   assign b_mag = b_reg[N-1] ? -b_reg : b_reg;
   assign neg_q = a_reg[2*N-1] ^ b_reg[N-1];
   assign neg_r = a_reg[2*N-1];
`else
   assign a_mag = a_reg;
   assign b_mag = b_reg;
`endif

   // One restoring step: the partial remainder stays below the divisor, so P fits in N bits.
   always_comb begin
      shifted = {p, s[N-1]};
      t       = shifted - {1'b0, b_mag};
      q_bit   = ~t[N];
      p_next  = q_bit ? t[N-1:0] : shifted[N-1:0];
      s_next  = {s[N-2:0], q_bit};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         p           <= '0;
         s           <= '0;
         q_res       <= '0;
         r_res       <= '0;
         cnt         <= '0;
         dz          <= 1'b0;
         ov          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg    <= a;
                  b_reg    <= b;
                  in_ready <= 1'b0;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               dz <= 1'b0;
               ov <= 1'b0;
               if (b_reg == '0) begin
                  q_res <= '1;
                  r_res <= a_reg[N-1:0];
                  dz    <= 1'b1;
                  state <= DONE;
               end else if (a_mag[2*N-1:N] >= b_mag) begin
                  q_res <= '1;
                  r_res <= '0;
                  ov    <= 1'b1;
                  state <= DONE;
               end else begin
                  p     <= a_mag[2*N-1:N];
                  s     <= a_mag[N-1:0];
                  cnt   <= CW'(N - 1);
                  state <= RUN;
               end
            end
            RUN: begin
               p     <= p_next;
               s     <= s_next;
               q_res <= s_next;
               r_res <= p_next;
               if (cnt == '0) begin
`ifdef DIVIDE_SIGNED_EN
                  state <= FIX;
`else
                  state <= DONE;
`endif
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
`ifdef DIVIDE_SIGNED_EN
            // Apply signs; a magnitude that cannot be represented becomes an overflow.
            FIX: begin
               if (neg_q ? (q_res > MIN_MAG) : (q_res >= MIN_MAG)) begin
                  q_res <= '1;
                  r_res <= '0;
                  ov    <= 1'b1;
               end else begin
                  q_res <= neg_q ? -q_res : q_res;
                  r_res <= neg_r ? -r_res : r_res;
               end
               state <= DONE;
            end
`endif
            DONE: begin
               if (!out_valid) begin
                  out_valid   <= 1'b1;
                  q           <= q_res;
                  r           <= r_res;
                  div_by_zero <= dz;
                  overflow    <= ov;
               end else if (out_ready) begin
                  out_valid   <= 1'b0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  in_ready    <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide (N=8): directed cases, reset abort, and randomized traffic.
module tb_divide;

   localparam int unsigned N = 8;
`ifdef DIVIDE_SIGNED_EN
   localparam int NL = N + 3;
`else
   localparam int NL = N + 2;
`endif

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      logic         ov;
      int           lat;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [2*N-1:0] a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   q;
   logic [N-1:0]   r;
   logic           div_by_zero;
   logic           overflow;

   exp_t sb[$];
   exp_t nxt;
   int   checks   = 0;
   int   errors   = 0;
   int   edges    = 0;
   int   acc_edge = 0;
   int   results  = 0;
   bit   accepted = 0;
   bit   lat_done = 0;

   divide #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference model built on native integer division.
   function automatic exp_t model(input logic [2*N-1:0] ma, input logic [N-1:0] mb);
      exp_t e;
`ifdef DIVIDE_SIGNED_EN
      int sa, sd, qq, am, bm, lim;
      sa  = $signed(ma);
      sd  = $signed(mb);
      lim = 1 << (N - 1);
      e   = '{q: '1, r: '0, dz: 1'b0, ov: 1'b0, lat: NL};
      if (mb == '0) begin
         e.r   = ma[N-1:0];
         e.dz  = 1'b1;
         e.lat = 2;
      end else begin
         qq = sa / sd;
         am = (sa < 0) ? -sa : sa;
         bm = (sd < 0) ? -sd : sd;
         if (qq >= lim || qq < -lim) begin
            e.ov = 1'b1;
            if ((am >> N) >= bm) e.lat = 2;
         end else begin
            e.q = N'(qq);
            e.r = N'(sa % sd);
         end
      end
`else
      int unsigned ua, ub;
      ua = 32'(ma);
      ub = 32'(mb);
      e  = '{q: '1, r: '0, dz: 1'b0, ov: 1'b0, lat: NL};
      if (ub == 0) begin
         e.r   = ma[N-1:0];
         e.dz  = 1'b1;
         e.lat = 2;
      end else if (ua / ub > (2**N) - 1) begin
         e.ov  = 1'b1;
         e.lat = 2;
      end else begin
         e.q = N'(ua / ub);
         e.r = N'(ua % ub);
      end
`endif
      return e;
   endfunction

   // One clock: sample at negedge, score handshakes, then advance past the next posedge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            e = sb[0];
            if (!lat_done) begin
               check("latency", 32'(edges - acc_edge), 32'(e.lat));
               lat_done = 1;
            end
            check("q", 32'(q), 32'(e.q));
            check("r", 32'(r), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            check("overflow", 32'(overflow), 32'(e.ov));
            check("busy_in_ready", 32'(in_ready), 32'd0);
            if (out_ready) begin
               e = sb.pop_front();
               lat_done = 0;
               results++;
            end
         end
      end else begin
         check("flags_low", 32'({div_by_zero, overflow}), 32'd0);
      end
      if (in_valid && in_ready) begin
         sb.push_back(nxt);
         acc_edge = edges + 1;
         accepted = 1;
      end
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic run_one(input logic [2*N-1:0] ta, input logic [N-1:0] tbv,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic edz, input logic eov, input int elat, input int hold);
      int r0;
      nxt       = '{q: eq, r: er, dz: edz, ov: eov, lat: elat};
      a         = ta;
      b         = tbv;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      accepted  = 0;
      for (int i = 0; i < 20 && !accepted; i++) tick();
      check("accept", 32'(accepted), 32'd1);
      in_valid = 1'b0;
      if (hold > 0) begin
         for (int i = 0; i < 40 && !out_valid; i++) tick();
         repeat (hold) tick();
         out_ready = 1'b1;
      end
      r0 = results;
      for (int i = 0; i < 40 && results == r0; i++) tick();
      check("result", 32'(results - r0), 32'd1);
      check("one_transfer", 32'(out_valid), 32'd0);
      check("ready_after", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int          r0;
      int          sent;
      int unsigned sel;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", 32'(q), 32'd0);
      check("rst_r", 32'(r), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
      rst_n = 1'b1;

      run_one(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, NL, 0);
      run_one(16'h0064, 8'h00, 8'hFF, 8'h64, 1'b1, 1'b0, 2, 0);
      run_one(16'h5600, 8'h56, 8'hFF, 8'h00, 1'b0, 1'b1, 2, 0);
`ifdef DIVIDE_SIGNED_EN
      run_one(16'h55FF, 8'h56, 8'hFF, 8'h00, 1'b0, 1'b1, NL, 0);
`else
      run_one(16'h55FF, 8'h56, 8'hFF, 8'h55, 1'b0, 1'b0, NL, 0);
`endif
      run_one(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, NL, 5);
`ifdef DIVIDE_SIGNED_EN
      run_one(16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, NL, 0);
      run_one(16'hC000, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 2, 0);
`endif

      // Reset while iterating must drop the operation silently.
      nxt       = model(16'h1234, 8'h56);
      a         = 16'h1234;
      b         = 8'h56;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      accepted  = 0;
      for (int i = 0; i < 20 && !accepted; i++) tick();
      check("rst_accept", 32'(accepted), 32'd1);
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      lat_done = 0;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (15) tick();

      // Randomized traffic with random valid/ready.
      r0       = results;
      sent     = 0;
      accepted = 0;
      for (int cyc = 0; cyc < 60000 && (results - r0) < 1000; cyc++) begin
         if (!in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
            b   = N'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            a = (2*N)'($urandom);
            if (sel > 1 && b != '0) a[2*N-1:N] = N'($urandom_range(0, 32'(b) - 1));
            nxt      = model(a, b);
            in_valid = 1'b1;
            accepted = 0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (accepted) begin
            accepted = 0;
            in_valid = 1'b0;
            sent++;
         end
      end
      check("random_count", 32'(results - r0), 32'd1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/divide.md
Name: divide

Overview:
- Iterative restoring divider; inverse of the combinational multiplier in the fixed-point arithmetic library.
- Accepts a 2N-bit dividend and an N-bit divisor; returns an N-bit quotient and an N-bit remainder, so a multiply product divides back to its operand.
- Processes one quotient bit per clock.
- Valid/ready handshakes on input and output; sits beside the multiplier in the FixedPointArithmetic units.

Parameters:
- N, 32, operand/result width in bits; divisor, quotient and remainder are N bits, dividend is 2N bits; legal N >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  2N  dividend
- b  input  N  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q  output  N  quotient
- r  output  N  remainder
- div_by_zero  output  1  b was zero; valid with out_valid
- overflow  output  1  quotient does not fit in N bits; valid with out_valid

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, in_ready=1.
  - out_valid=0, q=0, r=0, div_by_zero=0, overflow=0.
  - Reset mid-operation aborts the operation with no output; the operands are discarded.
- States: IDLE, CHECK, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register a and b and go to CHECK.
  - in_ready=0 in every other state.
- CHECK (1 cycle):
  - b==0: q=all ones, r=a[N-1:0], div_by_zero=1, overflow=0; go to DONE.
  - Else a[2N-1:N] >= b: q=all ones, r=0, overflow=1; go to DONE.
  - Else: partial remainder P (N+1 bits) = a[2N-1:N], shift register S = a[N-1:0], counter=N-1; go to RUN.
- RUN (N cycles):
  - T = {P[N-1:0], S[N-1]} - {1'b0, b}, computed at N+1 bits.
  - If T is non-negative: P=T and quotient bit=1; else P={P[N-1:0], S[N-1]} and quotient bit=0.
  - Quotient bits shift in MSB-first; S shifts left.
  - When counter==0, go to DONE; otherwise decrement the counter.
- DONE:
  - out_valid=1; q and r are registered and stable.
  - Outputs are held until out_valid&&out_ready; then go to IDLE, and out_valid is 0 on the next cycle.
- Latency from accept edge to out_valid:
  - Normal operation: N+2 cycles.
  - Zero divisor or overflow: 2 cycles.
- Throughput: one operation in flight; the next accept occurs no earlier than the cycle after the output handshake.
- Backpressure: out_ready low holds DONE indefinitely with all outputs stable.
- Flags are 0 whenever out_valid=0.
- Invariant, normal case: a == q*b + r, with r < b.
- in_valid while busy is ignored; the upstream must hold its operands until in_ready.

Optional Feature:
- Macro: DIVIDE_SIGNED_EN.
- Defined: a, b, q and r are two's complement.
  - Magnitudes are taken in CHECK and the unsigned iteration runs on them.
  - One extra FIX state follows RUN and applies signs: q is negated when sign(a)!=sign(b); r takes the sign of a (truncation toward zero).
  - overflow=1 when the quotient magnitude exceeds 2^(N-1)-1 for a positive result, or 2^(N-1) for a negative result.
  - Normal latency becomes N+3 cycles.
  - Zero-divisor result: q=all ones, r=a[N-1:0].
- Undefined: unsigned operation only, no FIX state, latency N+2 cycles.

Test Plan (N=8):
- Basic divide: a=16'h1234, b=8'h56 -> out_valid 10 cycles after accept, q=8'h36, r=8'h10, both flags 0.
- Zero divisor: a=16'h0064, b=0 -> out_valid 2 cycles after accept, q=8'hFF, r=8'h64, div_by_zero=1.
- Overflow: a=16'h5600, b=8'h56 -> 2 cycles, q=8'hFF, r=0, overflow=1; a=16'h55FF, b=8'h56 -> q=8'hFF, r=8'h55, overflow=0.
- Backpressure and reset:
  - a=16'h0064, b=7, with out_ready low for 5 cycles -> q=8'h0E and r=8'h02 held stable, in_ready=0 throughout, one transfer on out_ready.
  - Reset asserted during RUN -> next cycle out_valid=0, in_ready=1, no result emitted.
- Back-to-back with random stimulus: 1000 random operand pairs with random in_valid/out_ready -> every result matches a == q*b + r with r < b, or the correct flag.
- DIVIDE_SIGNED_EN: a=16'hFF9C (-100), b=8'h07 -> q=8'hF2 (-14), r=8'hFE (-2), latency 11 cycles; a=16'hC000, b=8'hFF -> overflow=1.
